scale_fifo_fwft_reader: RTL and testbench

Read-side drain engine for the scale FIFO. Pulls words from the FIFO's standard read port (`rd_en`/`rd_empty`/`rd_data`, one-cycle read latency, no output register) and presents them as a first-word-fall-through valid/ready stream with a per-line `m_last` marker. It sits between the scale FIFO and the downstream scaler datapath, in the read clock domain. It sustains one word per cycle without any combinational path from `m_ready` to the FIFO.

---
 rtl/scale_fifo_pkg.sv | 10 +
 rtl/scale_fifo_obuf.sv | 63 ++++++
 rtl/scale_fifo_fwft_reader.sv | 73 +++++++
 tb/tb_scale_fifo_fwft_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_fifo_pkg.sv
// Shared constants for the scale FIFO read path (output buffer geometry, default line length).
package scale_fifo_pkg;

  localparam int unsigned OBUF_DEPTH       = 3;
  localparam int unsigned OBUF_CNT_W       = 2;
  localparam int unsigned LINE_LEN_DEFAULT = 1920;

  typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;

endpackage

// File: rtl/scale_fifo_obuf.sv
// Three-entry register FIFO with head at entry 0; push and pop may coincide.
module scale_fifo_obuf
  import scale_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [c_DATA_WIDTH-1:0] head,
  output obuf_cnt_t               count
);

  logic [c_DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic [c_DATA_WIDTH-1:0] mem_d [OBUF_DEPTH];
  obuf_cnt_t               count_q;
  obuf_cnt_t               count_d;
  obuf_cnt_t               wr_idx;
  logic                    pop_ok;
  logic                    push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != OBUF_CNT_W'(OBUF_DEPTH)) || pop_ok);
    // Entries shift toward the head on pop, so the write slot follows the post-pop count.
    wr_idx  = count_q - obuf_cnt_t'(pop_ok);
    mem_d   = mem_q;
    if (pop_ok) begin
      for (int unsigned i = 0; i < OBUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (push_ok) begin
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        if (wr_idx == OBUF_CNT_W'(i)) begin
          mem_d[i] = push_data;
        end
      end
    end
    count_d = count_q + obuf_cnt_t'(push_ok) - obuf_cnt_t'(pop_ok);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/scale_fifo_fwft_reader.sv
// Drains the scale FIFO's latency-1 read port into a FWFT valid/ready stream with per-line last.
module scale_fifo_fwft_reader
  import scale_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_LINE_LEN   = LINE_LEN_DEFAULT,
  parameter int unsigned c_CNT_WIDTH  = 16
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    flush,
  output logic                    fifo_rd_en,
  input  logic                    fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [OBUF_CNT_W-1:0]   buf_count
);

  logic                   inflight_q;
  logic                   discard_q;
  logic [c_CNT_WIDTH-1:0] beat_q;
  logic [c_CNT_WIDTH-1:0] beat_d;
  logic [OBUF_CNT_W:0]    reserved;
  logic                   pop;
  logic                   push;
  obuf_cnt_t              count;

  always_comb begin
    // Each in-flight read holds a slot so the buffer cannot overflow; no m_ready dependency.
    reserved   = {1'b0, count} + {{OBUF_CNT_W{1'b0}}, inflight_q};
    fifo_rd_en = !fifo_rd_empty && !flush && !rd_rst
                 && (reserved < (OBUF_CNT_W + 1)'(OBUF_DEPTH));
    m_valid    = (count != '0);
    m_last     = m_valid && (beat_q == c_CNT_WIDTH'(c_LINE_LEN - 1));
    pop        = m_valid && m_ready;
    push       = inflight_q && !discard_q;
    beat_d     = beat_q;
    if (pop) begin
      beat_d = m_last ? '0 : beat_q + c_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      discard_q  <= flush && inflight_q;
      beat_q     <= flush ? '0 : beat_d;
    end
  end

  scale_fifo_obuf #(
    .c_DATA_WIDTH (c_DATA_WIDTH)
  ) u_obuf (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .clr       (flush),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (m_data),
    .count     (count)
  );

  assign buf_count = count;

endmodule

// File: tb/tb_scale_fifo_fwft_reader.sv
// Scoreboard bench: source FIFO model feeds the reader, monitor checks order, line markers and stalls.
module tb_scale_fifo_fwft_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned LL = 4;

  logic          rd_clk  = 1'b0;
  logic          rd_rst  = 1'b1;
  logic          flush   = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [1:0]    buf_count;

  always #5 rd_clk = ~rd_clk;

  scale_fifo_fwft_reader #(
    .c_DATA_WIDTH (DW),
    .c_LINE_LEN   (LL),
    .c_CNT_WIDTH  (16)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .flush         (flush),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_data  (fifo_rd_data),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .buf_count     (buf_count)
  );

  // Source FIFO: stimulus owns src_wr, the read port owns src_rd.
  logic [DW-1:0] src_mem [256];
  int unsigned   src_wr = 0;
  int unsigned   src_rd = 0;

  assign fifo_rd_empty = (src_rd == src_wr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= src_mem[src_rd % 256];
      src_rd       <= src_rd + 1;
    end
  end

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned beats = 0;
  int unsigned lasts_seen = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    src_mem[src_wr % 256] = d;
    exp_q.push_back('{src_wr, d});
    src_wr++;
  endtask

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge rd_clk);
      if (exp_q.size() == 0 && !m_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout with %0d words outstanding, expected 0", name, exp_q.size());
  endtask

  // Monitor: words already pulled from the source are lost on flush/reset; beats restart at 0.
  always @(negedge rd_clk) begin
    if (rd_rst || flush) begin
      while (exp_q.size() > 0 && exp_q[0].idx < src_rd) void'(exp_q.pop_front());
      beats   = 0;
      stall_q = 1'b0;
    end else begin
      check("valid_vs_count", DW'(m_valid), DW'(buf_count != 2'd0));
      if (!m_valid) check("last_without_valid", DW'(m_last), '0);
      if (stall_q) begin
        check("stall_valid", DW'(m_valid), DW'(1));
        check("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got 0x%0h, expected no beat", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", m_data, mon_e.data);
          check("beat_last", DW'(m_last), DW'((beats % LL) == LL - 1));
        end
        beats++;
        if (m_last) lasts_seen++;
      end
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int          en_cnt;
    int          v_cnt;
    int          first_v;
    int          en_late;
    int unsigned lasts0;
    bit          hit;

    repeat (3) tick;
    @(negedge rd_clk);
    check("rst_rd_en", DW'(fifo_rd_en), '0);
    check("rst_valid", DW'(m_valid), '0);
    check("rst_last", DW'(m_last), '0);
    check("rst_buf_count", DW'(buf_count), '0);

    // Cold start
    tick;
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    tick;
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    en_cnt = 0; v_cnt = 0; first_v = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) en_cnt++;
      if (m_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = k;
      end
    end
    check("cold_rd_en_cycles", DW'(en_cnt), DW'(3));
    check("cold_first_valid", DW'(first_v), DW'(2));
    check("cold_valid_cycles", DW'(v_cnt), DW'(3));

    // Back-pressure
    tick;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word($urandom);
    en_late = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge rd_clk);
      if (k >= 4 && fifo_rd_en) en_late++;
    end
    check("bp_buf_count_sat", DW'(buf_count), DW'(3));
    check("bp_rd_en_low", DW'(en_late), '0);
    tick;
    m_ready = 1'b1;
    wait_drain(40, "bp_drain");
    check("bp_all_delivered", DW'(exp_q.size()), '0);

    // Line marker under random ready
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    lasts0 = lasts_seen;
    for (int i = 0; i < 12; i++) push_word($urandom);
    for (int k = 0; k < 200; k++) begin
      tick;
      m_ready = 1'($urandom_range(0, 1));
      @(negedge rd_clk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    tick;
    m_ready = 1'b1;
    wait_drain(20, "line_drain");
    check("line_last_count", DW'(lasts_seen - lasts0), DW'(3));

    // Flush with a read in flight, after a partial line
    push_word($urandom);
    push_word($urandom);
    wait_drain(20, "pre_flush_drain");
    tick;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    @(negedge rd_clk);
    check("fl_issue", DW'(fifo_rd_en), DW'(1));
    tick;
    flush = 1'b1;
    @(negedge rd_clk);
    check("fl_rd_en_forced_low", DW'(fifo_rd_en), '0);
    tick;
    flush = 1'b0;
    @(negedge rd_clk);
    check("fl_buf_cleared", DW'(buf_count), '0);
    check("fl_valid_cleared", DW'(m_valid), '0);
    check("fl_restart_rd_en", DW'(fifo_rd_en), DW'(1));
    tick;
    m_ready = 1'b1;
    wait_drain(30, "fl_drain");

    // Mid-stream reset with a full buffer
    tick;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word($urandom);
    hit = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge rd_clk);
      if (buf_count == 2'd3) begin
        hit = 1'b1;
        break;
      end
    end
    check("mr_buf_full", DW'(hit), DW'(1));
    tick;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    check("mr_rd_en_low", DW'(fifo_rd_en), '0);
    tick;
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    @(negedge rd_clk);
    check("mr_valid0", DW'(m_valid), '0);
    check("mr_last0", DW'(m_last), '0);
    check("mr_buf_count0", DW'(buf_count), '0);
    check("mr_rd_en_restart", DW'(fifo_rd_en), DW'(1));
    @(negedge rd_clk);
    check("mr_valid1", DW'(m_valid), '0);
    @(negedge rd_clk);
    check("mr_valid2", DW'(m_valid), DW'(1));
    wait_drain(30, "mr_drain");

    check("final_scoreboard_empty", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
